// File: rtl/smoosh_pkg.sv
// Shared types for the player movement/animation pipeline.
// movement_state is consumed by the animation stage as well.
package smoosh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } movement_state;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic logic is_grounded(input movement_state s);
    return (s == IDLE) || (s == WALK);
  endfunction

endpackage

// File: rtl/player_vert_phys.sv
// Vertical integrator: vy/y with gravity, ceiling clamp and floor landing.
// landed/to_fall are combinational hints for the owning FSM.
import smoosh_pkg::*;

module player_vert_phys #(
  parameter int Y_GROUND = 400,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          launch,
  input  movement_state mode,
  output logic [10:0]   pos_y,
  output logic          landed,
  output logic          to_fall
);

  localparam logic signed [11:0] GROUND_S = 12'(Y_GROUND);
  localparam logic signed [5:0]  JUMP_V   = 6'(-JUMP_VEL);
  localparam logic signed [5:0]  GRAV     = 6'(GRAVITY);
  localparam logic signed [5:0]  MAXF     = 6'(MAX_FALL);

  logic signed [5:0]  vy;
  logic signed [5:0]  vy_g;
  logic signed [5:0]  vy_f;
  logic signed [5:0]  vy_d;
  logic signed [11:0] y_s;
  logic signed [11:0] jump_y;
  logic signed [11:0] fall_y;
  logic [10:0]        y_d;
  logic               ceiling;

  always_comb begin
    vy_g    = vy + GRAV;
    vy_f    = (vy_g > MAXF) ? MAXF : vy_g;
    y_s     = $signed({1'b0, pos_y});
    jump_y  = y_s + {{6{vy[5]}}, vy};
    fall_y  = y_s + {{6{vy_f[5]}}, vy_f};
    ceiling = jump_y < 12'sd0;
    to_fall = (mode == JUMP) && (ceiling || !vy_g[5]);
    landed  = (mode == FALL) && (fall_y >= GROUND_S);
  end

  always_comb begin
    y_d  = pos_y;
    vy_d = vy;
    if (launch) begin
      vy_d = JUMP_V;
    end else begin
      unique case (mode)
        JUMP: begin
          if (ceiling) begin
            y_d  = '0;
            vy_d = '0;
          end else begin
            y_d  = jump_y[10:0];
            vy_d = vy_g;
          end
        end
        FALL: begin
          if (landed) begin
            y_d  = 11'(Y_GROUND);
            vy_d = '0;
          end else begin
            y_d  = fall_y[10:0];
            vy_d = vy_f;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_y <= 11'(Y_GROUND);
      vy    <= '0;
    end else if (tick) begin
      pos_y <= y_d;
      vy    <= vy_d;
    end
  end

endmodule

// File: rtl/player_movement_fsm.sv
// Per-player movement FSM: buttons, horizontal clamp, state and facing.
// Define DOUBLE_JUMP_EN to allow one extra jump per airtime.
import smoosh_pkg::*;

module player_movement_fsm #(
  parameter int X_START    = 320,
  parameter int Y_GROUND   = 400,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = SCREEN_W - 46,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_jump,
  output movement_state move_anim,
  output logic [10:0]   pos_x,
  output logic [10:0]   pos_y,
  output logic          facing_left,
  output logic          on_ground
);

  localparam logic signed [11:0] STEP   = 12'(WALK_SPEED);
  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);

  movement_state      state_d;
  logic               jump_prev;
  logic               jump_edge;
  logic               dir;
  logic               dir_left;
  logic               grounded;
  logic               air_ok;
  logic               launch;
  logic               landed;
  logic               to_fall;
  logic signed [11:0] x_s;
  logic [10:0]        x_d;

  assign jump_edge = btn_jump & ~jump_prev;
  assign dir       = btn_left ^ btn_right;
  assign dir_left  = btn_left & ~btn_right;
  assign grounded  = is_grounded(move_anim);
  // a landing tick swallows any jump edge seen on it
  assign launch    = frame_tick & jump_edge & ~landed & (grounded | air_ok);

`ifdef DOUBLE_JUMP_EN
  logic air_jump_used;
  assign air_ok = ~air_jump_used;

  always_ff @(posedge clk) begin
    if (reset) begin
      air_jump_used <= 1'b0;
    end else if (frame_tick) begin
      if (landed)
        air_jump_used <= 1'b0;
      else if (launch && !grounded)
        air_jump_used <= 1'b1;
    end
  end
`else
  assign air_ok = 1'b0;
`endif

  player_vert_phys #(
    .Y_GROUND (Y_GROUND),
    .JUMP_VEL (JUMP_VEL),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_vert (
    .clk     (clk),
    .reset   (reset),
    .tick    (frame_tick),
    .launch  (launch),
    .mode    (move_anim),
    .pos_y   (pos_y),
    .landed  (landed),
    .to_fall (to_fall)
  );

  always_comb begin
    x_s = $signed({1'b0, pos_x}) + (dir_left ? -STEP : STEP);
    if (x_s < XMIN_S)
      x_d = 11'(X_MIN);
    else if (x_s > XMAX_S)
      x_d = 11'(X_MAX);
    else
      x_d = x_s[10:0];
  end

  always_comb begin
    state_d = move_anim;
    if (launch) begin
      state_d = JUMP;
    end else if (landed) begin
      state_d = dir ? WALK : IDLE;
    end else begin
      unique case (move_anim)
        IDLE: if (dir) state_d = WALK;
        WALK: if (!dir) state_d = IDLE;
        JUMP: if (to_fall) state_d = FALL;
        FALL: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      move_anim   <= IDLE;
      pos_x       <= 11'(X_START);
      facing_left <= 1'b0;
      on_ground   <= 1'b1;
      jump_prev   <= 1'b1;
    end else if (frame_tick) begin
      move_anim <= state_d;
      on_ground <= is_grounded(state_d);
      jump_prev <= btn_jump;
      if (dir) begin
        pos_x       <= x_d;
        facing_left <= dir_left;
      end
    end
  end

endmodule
